// File: rtl/sram_like_resp.sv
// Responder end of the sram-like bus: word memory with byte-lane writes and
// fixed-latency, in-order data_ok responses. SRAM_LIKE_RESP_STALL_EN adds LFSR backpressure.
module sram_like_resp #(
  parameter int ADDR_W = 12,
  parameter int LAT    = 2,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0]       LAT_V  = 4'(LAT);
  localparam logic [CNT_W-1:0] FULL_V = CNT_W'(QDEPTH);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] widx;
  logic [3:0]        be;
  logic              push;
  logic              pop;
  logic              room;
  logic [1:0]        rst_sync;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              q_wr   [QDEPTH];
  logic [31:0]       q_word [QDEPTH];
  logic [3:0]        q_age  [QDEPTH];
  logic              unused_addr_bits;

  assign widx             = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  always_comb begin
    be = 4'b0000;
    case (size)
      2'd0:    be[addr[1:0]] = 1'b1;
      2'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory contents survive reset; only the request path is gated by it.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign room = (count != FULL_V);

`ifdef SRAM_LIKE_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign addr_ok = rst_sync[1] & room & ~lfsr[0];
`else
  assign addr_ok = rst_sync[1] & room;
`endif

  assign push    = req & addr_ok;
  assign data_ok = (count != '0) && (q_age[rd_ptr] == LAT_V);
  assign pop     = data_ok;
  assign rdata   = (data_ok && !q_wr[rd_ptr]) ? q_word[rd_ptr] : 32'h0;

  // Ages of idle slots also saturate; they are re-seeded to 1 on push, so it is harmless.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_wr[i]   <= 1'b0;
        q_word[i] <= 32'h0;
        q_age[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_age[i] != LAT_V) q_age[i] <= q_age[i] + 4'd1;
      end
      if (push) begin
        q_wr[wr_ptr]   <= wr;
        q_word[wr_ptr] <= wr ? 32'h0 : mem[widx];
        q_age[wr_ptr]  <= 4'd1;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
